// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control bit positions, index width and the
// in-flight slot record used by the register-read scoreboard.
package pipe_pkg;

   localparam int CTRL_W        = 7;
   localparam int IDX_W         = 3;
   localparam int CTRL_REG_WE   = 0;
   localparam int CTRL_SRC1_RD  = 1;
   localparam int CTRL_SRC2_RD  = 2;
   localparam int DEFAULT_DEPTH = 3;

   typedef logic [IDX_W-1:0] idx_t;

   typedef struct packed {
      logic valid;
      logic we;
      idx_t idx;
   } slot_t;

endpackage

// File: rtl/rr_scoreboard_if.sv
// Decode->RR instruction handshake plus the issue and write-back reports.
interface rr_scoreboard_if;
   import pipe_pkg::*;

   logic              valid_in;
   logic [CTRL_W-1:0] ctrl_in;
   idx_t              src1_idx;
   idx_t              src2_idx;
   logic              flush;
   logic              stall;
   logic              issue_valid;
   logic              issue_we;
   idx_t              issue_dst;
   logic              wb_valid;
   idx_t              wb_idx;

   modport master (
      output valid_in, ctrl_in, src1_idx, src2_idx, flush,
      input  stall, issue_valid, issue_we, issue_dst, wb_valid, wb_idx
   );

   modport slave (
      input  valid_in, ctrl_in, src1_idx, src2_idx, flush,
      output stall, issue_valid, issue_we, issue_dst, wb_valid, wb_idx
   );

endinterface

// File: rtl/rr_hazard_cmp.sv
// Flags whether any in-flight slot is a pending writer of the given index.
module rr_hazard_cmp
   import pipe_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  slot_t [DEPTH-1:0] slots,
   input  idx_t              idx,
   output logic              hit
);

   // NOTE: hit gets its default before the loop so no path leaves it
   // unassigned, which is what keeps combinational logic free of latches.
   always_comb begin
      hit = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         if (slots[k].valid && slots[k].we && (slots[k].idx == idx))
            hit = 1'b1;
      end
   end

endmodule

// File: rtl/rr_scoreboard.sv
// Register-read hazard controller: stalls readers of destinations still in
// flight between EX and WB, with no bypass, and reports their write-back.
module rr_scoreboard
   import pipe_pkg::*;
#(
   parameter int DEPTH       = DEFAULT_DEPTH,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   rr_scoreboard_if.slave         bus,
   output logic [2:0]             inflight,
   output logic [STALL_CNT_W-1:0] stall_cycles
);

   slot_t [DEPTH-1:0] slots;
   slot_t [DEPTH-1:0] slots_next;
   slot_t             slot_in;
   logic [2:0]        inflight_next;
   logic              hit1;
   logic              hit2;
   logic              hazard;
   logic              issue_valid;
   logic              unused_ctrl;

   assign unused_ctrl = ^bus.ctrl_in[CTRL_W-1:3];

   rr_hazard_cmp #(.DEPTH(DEPTH)) u_cmp_src1 (
      .slots (slots),
      .idx   (bus.src1_idx),
      .hit   (hit1)
   );

   rr_hazard_cmp #(.DEPTH(DEPTH)) u_cmp_src2 (
      .slots (slots),
      .idx   (bus.src2_idx),
      .hit   (hit2)
   );

   // Only slots are compared, so an instruction never hazards on its own dest.
   assign hazard = bus.valid_in &
                   ((bus.ctrl_in[CTRL_SRC1_RD] & hit1) |
                    (bus.ctrl_in[CTRL_SRC2_RD] & hit2));

   assign issue_valid     = bus.valid_in & ~hazard & ~bus.flush;
   assign bus.issue_valid = issue_valid;
   assign bus.issue_we    = issue_valid & bus.ctrl_in[CTRL_REG_WE];
   assign bus.issue_dst   = bus.src1_idx;
   assign bus.stall       = hazard & ~bus.flush;
   assign bus.wb_valid    = slots[DEPTH-1].valid & slots[DEPTH-1].we;
   assign bus.wb_idx      = slots[DEPTH-1].idx;

   // The pipe always advances; a stalled or flushed RR stage shifts in a bubble.
   always_comb begin
      slot_in       = '{valid: issue_valid, we: bus.issue_we, idx: bus.src1_idx};
      slots_next    = {slots[DEPTH-2:0], slot_in};
      inflight_next = '0;
      for (int k = 0; k < DEPTH; k++)
         inflight_next = inflight_next + {2'b00, slots_next[k].valid};
   end

   // NOTE: state uses non-blocking assignments, and every slot is reset so an
   // asynchronous reset clears pending writers and drops stall immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slots        <= '0;
         inflight     <= '0;
         stall_cycles <= '0;
      end else begin
         slots    <= slots_next;
         inflight <= inflight_next;
         if (bus.stall && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 1'b1;
      end
   end

endmodule

// File: tb/tb_rr_scoreboard.sv
// Directed bench for rr_scoreboard (DEPTH=3, 4-bit stall counter).
module tb_rr_scoreboard;
   import pipe_pkg::*;

   localparam int DEPTH       = 3;
   localparam int STALL_CNT_W = 4;

   logic                   clk;
   logic                   rst;
   logic [2:0]             inflight;
   logic [STALL_CNT_W-1:0] stall_cycles;
   int                     n_tests;
   int                     n_fail;

   rr_scoreboard_if bus ();

   rr_scoreboard #(.DEPTH(DEPTH), .STALL_CNT_W(STALL_CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .inflight     (inflight),
      .stall_cycles (stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] ctrl, input logic [2:0] s1,
                        input logic [2:0] s2, input logic fl);
      bus.valid_in = v;
      bus.ctrl_in  = {4'b0000, ctrl};
      bus.src1_idx = s1;
      bus.src2_idx = s2;
      bus.flush    = fl;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      drive(1'b0, 3'b000, 3'd0, 3'd0, 1'b0);
      next_cycle();
      rst = 1'b1;
   endtask

   initial begin
      int stalls;
      n_tests = 0;
      n_fail  = 0;

      // Reset state, then a read+write of r2 issues against empty slots.
      rst = 1'b0;
      drive(1'b0, 3'b000, 3'd0, 3'd0, 1'b0);
      #12;
      check("rst_inflight", inflight, 0);
      check("rst_wb_valid", bus.wb_valid, 0);
      check("rst_stall_cycles", stall_cycles, 0);
      check("rst_stall", bus.stall, 0);
      next_cycle();
      rst = 1'b1;
      drive(1'b1, 3'b011, 3'd2, 3'd0, 1'b0);
      @(negedge clk);
      check("first_stall", bus.stall, 0);
      check("first_issue_valid", bus.issue_valid, 1);
      check("first_issue_we", bus.issue_we, 1);
      check("first_issue_dst", bus.issue_dst, 2);
      next_cycle();
      check("first_inflight", inflight, 1);
      check("first_stall_cycles", stall_cycles, 0);

      // RAW on src1: writer r3 at cycle 0, reader stalls cycles 1-3.
      do_reset();
      drive(1'b1, 3'b001, 3'd3, 3'd0, 1'b0);
      @(negedge clk);
      check("raw_writer_issue", bus.issue_valid, 1);
      next_cycle();
      drive(1'b1, 3'b010, 3'd3, 3'd0, 1'b0);
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         check($sformatf("raw_stall_c%0d", c), bus.stall, 1);
         check($sformatf("raw_noissue_c%0d", c), bus.issue_valid, 0);
         check($sformatf("raw_wb_valid_c%0d", c), bus.wb_valid, (c == 3) ? 1 : 0);
         if (c == 3) check("raw_wb_idx", bus.wb_idx, 3);
         next_cycle();
      end
      @(negedge clk);
      check("raw_stall_c4", bus.stall, 0);
      check("raw_issue_c4", bus.issue_valid, 1);
      check("raw_stall_cycles", stall_cycles, 3);
      check("raw_inflight_c4", inflight, 0);
      next_cycle();
      drive(1'b0, 3'b000, 3'd0, 3'd0, 1'b0);

      // src2 read gated by ctrl bit2.
      do_reset();
      drive(1'b1, 3'b001, 3'd5, 3'd0, 1'b0);
      next_cycle();
      drive(1'b1, 3'b000, 3'd0, 3'd5, 1'b0);
      @(negedge clk);
      check("src2_gated_stall", bus.stall, 0);
      check("src2_gated_issue", bus.issue_valid, 1);
      check("src2_gated_we", bus.issue_we, 0);
      do_reset();
      drive(1'b1, 3'b001, 3'd5, 3'd0, 1'b0);
      next_cycle();
      drive(1'b1, 3'b100, 3'd0, 3'd5, 1'b0);
      stalls = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus.issue_valid) break;
         if (bus.stall) stalls++;
         next_cycle();
      end
      check("src2_issued", bus.issue_valid, 1);
      check("src2_stall_count", stalls, 3);
      next_cycle();
      drive(1'b0, 3'b000, 3'd0, 3'd0, 1'b0);

      // Flush during a stall on r1.
      do_reset();
      drive(1'b1, 3'b001, 3'd1, 3'd0, 1'b0);
      next_cycle();
      drive(1'b1, 3'b010, 3'd1, 3'd0, 1'b0);
      @(negedge clk);
      check("flush_pre_stall", bus.stall, 1);
      next_cycle();
      check("flush_pre_inflight", inflight, 1);
      drive(1'b1, 3'b010, 3'd1, 3'd0, 1'b1);
      @(negedge clk);
      check("flush_stall", bus.stall, 0);
      check("flush_issue", bus.issue_valid, 0);
      next_cycle();
      drive(1'b0, 3'b000, 3'd0, 3'd0, 1'b0);
      check("flush_inflight", inflight, 1);
      check("flush_wb_valid", bus.wb_valid, 1);
      check("flush_wb_idx", bus.wb_idx, 1);
      check("flush_stall_cycles", stall_cycles, 1);

      // Fill the pipe with independent writers, then async reset mid-stall.
      do_reset();
      drive(1'b1, 3'b001, 3'd4, 3'd0, 1'b0);
      next_cycle();
      drive(1'b1, 3'b001, 3'd5, 3'd0, 1'b0);
      next_cycle();
      drive(1'b1, 3'b001, 3'd6, 3'd0, 1'b0);
      next_cycle();
      check("fill_inflight3", inflight, 3);
      check("fill_wb_valid", bus.wb_valid, 1);
      check("fill_wb_idx4", bus.wb_idx, 4);
      drive(1'b1, 3'b001, 3'd7, 3'd0, 1'b0);
      next_cycle();
      check("fill_inflight_sat", inflight, 3);
      check("fill_wb_idx5", bus.wb_idx, 5);
      drive(1'b1, 3'b010, 3'd7, 3'd0, 1'b0);
      @(negedge clk);
      check("arst_pre_stall", bus.stall, 1);
      #1 rst = 1'b0;
      #1;
      check("arst_inflight", inflight, 0);
      check("arst_wb_valid", bus.wb_valid, 0);
      check("arst_stall", bus.stall, 0);
      check("arst_issue", bus.issue_valid, 1);
      drive(1'b0, 3'b000, 3'd0, 3'd0, 1'b0);
      next_cycle();
      rst = 1'b1;

      // Counter saturation: a self-dependent r1 read+write stalls 3 of every 4 cycles.
      do_reset();
      drive(1'b1, 3'b011, 3'd1, 3'd0, 1'b0);
      stalls = 0;
      for (int c = 0; c < 28; c++) begin
         @(negedge clk);
         if (bus.stall) stalls++;
         next_cycle();
      end
      check("sat_observed_stalls", stalls, 21);
      check("sat_stall_cycles", stall_cycles, 15);
      drive(1'b0, 3'b000, 3'd0, 3'd0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
